// File: rtl/video_pkg.sv
// Shared video definitions: pattern select codes and the colour-bar palette,
// used by the pattern generator and by downstream image-processing blocks.
package video_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GREY  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Standard left-to-right bar order.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = RGB_WHITE;
      3'd1:    bar_rgb = RGB_YELLOW;
      3'd2:    bar_rgb = RGB_CYAN;
      3'd3:    bar_rgb = RGB_GREEN;
      3'd4:    bar_rgb = RGB_MAGENTA;
      3'd5:    bar_rgb = RGB_RED;
      3'd6:    bar_rgb = RGB_BLUE;
      default: bar_rgb = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Raster h/v counters with region decode; sync and DE are registered so they
// line up with pixel data registered from the same counter state.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             active,
  output logic             frame_origin,
  output logic             first_active,
  output logic             last_pixel,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic             hs,
  output logic             vs,
  output logic             de
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt_reg;
  logic [CNT_W-1:0] v_cnt_reg;
  logic             h_sync;
  logic             v_sync;
  logic             h_act;
  logic             v_act;
  logic             hs_reg;
  logic             vs_reg;
  logic             de_reg;

  // Counters sit at the frame origin whenever the generator is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (!run) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    h_sync = (h_cnt_reg < H_SYNC_END);
    v_sync = (v_cnt_reg < V_SYNC_END);
    h_act  = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END);
    v_act  = (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);
  end

  assign active       = run && h_act && v_act;
  assign frame_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign first_active = run && (h_cnt_reg == H_ACT_BEG) && (v_cnt_reg == V_ACT_BEG);
  assign last_pixel   = run && (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
  assign pos_x        = h_cnt_reg - H_ACT_BEG;
  assign pos_y        = v_cnt_reg - V_ACT_BEG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_reg <= ~HS_POL;
      vs_reg <= ~VS_POL;
      de_reg <= 1'b0;
    end else begin
      hs_reg <= (run && h_sync) ? HS_POL : ~HS_POL;
      vs_reg <= (run && v_sync) ? VS_POL : ~VS_POL;
      de_reg <= active;
    end
  end

  assign hs = hs_reg;
  assign vs = vs_reg;
  assign de = de_reg;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: run/drain/idle control, per-frame pattern latch
// and pixel generation on top of the shared raster timing counter.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic [1:0]  I_pattern_sel,
  input  logic [23:0] I_solid_rgb,
  output logic        O_vs,
  output logic        O_hs,
  output logic        O_de,
  output logic [23:0] O_rgb,
  output logic        O_frame_start,
  output logic [15:0] O_frame_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             run;
  logic             active;
  logic             frame_origin;
  logic             first_active;
  logic             last_pixel;
  logic [CNT_W-1:0] pos_x;
  logic [CNT_W-1:0] pos_y;
  pattern_e         pattern_reg;
  logic [23:0]      solid_reg;
  logic [CNT_W-1:0] bar_cnt_reg;
  logic [2:0]       bar_idx_reg;
  logic [23:0]      pixel_next;
  logic [23:0]      rgb_reg;
  logic             frame_start_reg;
  logic [15:0]      frame_cnt_reg;
  logic             unused_pos;

  assign run        = (state_reg != ST_IDLE);
  assign unused_pos = ^{pos_x[CNT_W-1:8], pos_y[CNT_W-1:5], pos_y[3:0]};

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .clk          (I_clk),
    .rst_n        (I_rst_n),
    .run          (run),
    .active       (active),
    .frame_origin (frame_origin),
    .first_active (first_active),
    .last_pixel   (last_pixel),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .hs           (O_hs),
    .vs           (O_vs),
    .de           (O_de)
  );

  // A stop request never truncates a frame: DRAIN finishes it first.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (I_enable) state_next = ST_RUN;
      ST_RUN:   if (!I_enable) state_next = last_pixel ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (I_enable)        state_next = ST_RUN;
        else if (last_pixel) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pattern_reg <= PAT_BARS;
      solid_reg   <= '0;
    end else if (frame_origin) begin
      pattern_reg <= pattern_e'(I_pattern_sel);
      solid_reg   <= I_solid_rgb;
    end
  end

  // Bar index advances every BAR_W active pixels, restarting on each line.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (!active) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (bar_cnt_reg == BAR_LAST) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= bar_idx_reg + 3'd1;
    end else begin
      bar_cnt_reg <= bar_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    pixel_next = RGB_BLACK;
    case (pattern_reg)
      PAT_BARS:  pixel_next = bar_rgb(bar_idx_reg);
      PAT_GREY:  pixel_next = {3{pos_x[7:0]}};
      PAT_SOLID: pixel_next = solid_reg;
      PAT_CHECK: pixel_next = (pos_x[4] ^ pos_y[4]) ? RGB_WHITE : RGB_BLACK;
      default:   pixel_next = RGB_BLACK;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rgb_reg         <= '0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      rgb_reg         <= active ? pixel_next : RGB_BLACK;
      frame_start_reg <= first_active;
      if (last_pixel) frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign O_rgb         = rgb_reg;
  assign O_frame_start = frame_start_reg;
  assign O_frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a tiny 22x7 raster (16x4 active).
module tb_video_pattern_gen;

  logic        I_clk;
  logic        I_rst_n;
  logic        I_enable;
  logic [1:0]  I_pattern_sel;
  logic [23:0] I_solid_rgb;
  logic        O_vs;
  logic        O_hs;
  logic        O_de;
  logic [23:0] O_rgb;
  logic        O_frame_start;
  logic [15:0] O_frame_cnt;

  int checks   = 0;
  int failures = 0;

  video_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_enable      (I_enable),
    .I_pattern_sel (I_pattern_sel),
    .I_solid_rgb   (I_solid_rgb),
    .O_vs          (O_vs),
    .O_hs          (O_hs),
    .O_de          (O_de),
    .O_rgb         (O_rgb),
    .O_frame_start (O_frame_start),
    .O_frame_cnt   (O_frame_cnt)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_exp(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int pat, input int x, input int y, input logic [23:0] solid);
    logic [7:0] xb;
    xb = x[7:0];
    case (pat)
      0: return bar_exp(x / 2);
      1: return {xb, xb, xb};
      2: return solid;
      default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Follows one frame up to its last pixel; optionally changes inputs after
  // the sw_at-th active pixel. exp_wait = samples until O_frame_start.
  task automatic scan_frame(input string tag, input int exp_pat, input logic [23:0] exp_solid,
                            input int exp_wait, input int sw_at, input logic [1:0] sw_sel,
                            input logic [23:0] sw_solid, input logic sw_en);
    logic [15:0] fc0;
    logic [15:0] fc_exp;
    int k, de_n, hs_n, vs_n, fs_n, fs_at, blank_nz, x, y;
    fc0 = O_frame_cnt;
    fc_exp = fc0 + 16'd1;
    k = 0; de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; fs_at = -1; blank_nz = 0; x = 0; y = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge I_clk);
      k = i;
      if (!O_hs) hs_n++;
      if (!O_vs) vs_n++;
      if (O_frame_start) begin
        fs_n++;
        fs_at = i;
      end
      if (O_de) begin
        check_eq($sformatf("%s pix x%0d y%0d", tag, x, y), O_rgb, exp_pix(exp_pat, x, y, exp_solid));
        if (de_n == sw_at) begin
          I_pattern_sel = sw_sel;
          I_solid_rgb   = sw_solid;
          I_enable      = sw_en;
        end
        de_n++;
        x++;
      end else begin
        if (O_rgb != 24'h0) blank_nz++;
        if (x != 0) begin
          x = 0;
          y++;
        end
      end
      if (O_frame_cnt != fc0) break;
    end
    check_eq({tag, " fs_wait"}, fs_at, exp_wait);
    check_eq({tag, " fs_pulses"}, fs_n, 1);
    check_eq({tag, " frame_len"}, k, exp_wait + 105);
    check_eq({tag, " de_cycles"}, de_n, 64);
    check_eq({tag, " hs_low"}, hs_n, 14);
    check_eq({tag, " vs_low"}, vs_n, 22);
    check_eq({tag, " blank_rgb_nonzero"}, blank_nz, 0);
    check_eq({tag, " frame_cnt"}, O_frame_cnt, fc_exp);
    $display("frame %s done: de=%0d len=%0d fs_at=%0d frame_cnt=%0h", tag, de_n, k, fs_at, O_frame_cnt);
  endtask

  initial begin
    int de_n, hs_n, vs_n, fs_n, found;
    I_rst_n       = 1'b0;
    I_enable      = 1'b0;
    I_pattern_sel = 2'd0;
    I_solid_rgb   = 24'h0;
    repeat (3) @(negedge I_clk);
    check_eq("rst de", O_de, 0);
    check_eq("rst rgb", O_rgb, 0);
    check_eq("rst fs", O_frame_start, 0);
    check_eq("rst fcnt", O_frame_cnt, 0);
    check_eq("rst hs", O_hs, 1);
    check_eq("rst vs", O_vs, 1);
    I_rst_n = 1'b1;
    repeat (3) @(negedge I_clk);
    check_eq("idle hs", O_hs, 1);
    check_eq("idle de", O_de, 0);

    // Bars, then grey, solid, mid-frame switch to checker, then solid with stop.
    I_enable = 1'b1;
    scan_frame("f1_bars", 0, 24'h0, 50, 10, 2'd1, 24'h0, 1'b1);
    scan_frame("f2_grey", 1, 24'h0, 49, 10, 2'd2, 24'h123456, 1'b1);
    scan_frame("f3_solid", 2, 24'h123456, 49, 20, 2'd3, 24'hABCDEF, 1'b1);
    scan_frame("f4_check", 3, 24'h0, 49, 5, 2'd2, 24'hABCDEF, 1'b1);
    scan_frame("f5_drain", 2, 24'hABCDEF, 49, 30, 2'd1, 24'hABCDEF, 1'b0);

    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge I_clk);
      if (O_de) de_n++;
      if (!O_hs) hs_n++;
      if (!O_vs) vs_n++;
      if (O_frame_start) fs_n++;
    end
    check_eq("idle_after_drain de", de_n, 0);
    check_eq("idle_after_drain hs_low", hs_n, 0);
    check_eq("idle_after_drain vs_low", vs_n, 0);
    check_eq("idle_after_drain fs", fs_n, 0);
    check_eq("idle_after_drain fcnt", O_frame_cnt, 5);
    check_eq("idle_after_drain rgb", O_rgb, 0);

    I_enable = 1'b1;
    scan_frame("f6_reenable", 1, 24'h0, 50, -1, 2'd1, 24'h0, 1'b1);

    force dut.frame_cnt_reg = 16'hFFFF;
    #1;
    release dut.frame_cnt_reg;
    #1;
    check_eq("preload fcnt", O_frame_cnt, 16'hFFFF);
    scan_frame("f7_wrap", 1, 24'h0, 49, -1, 2'd1, 24'h0, 1'b1);
    check_eq("fcnt wrap", O_frame_cnt, 16'h0000);

    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge I_clk);
      if (O_de) begin
        found = 1;
        break;
      end
    end
    check_eq("mid_line de seen", found, 1);
    repeat (3) @(negedge I_clk);
    #2;
    I_rst_n = 1'b0;
    #1;
    check_eq("async_rst de", O_de, 0);
    check_eq("async_rst rgb", O_rgb, 0);
    check_eq("async_rst fs", O_frame_start, 0);
    check_eq("async_rst fcnt", O_frame_cnt, 0);
    check_eq("async_rst hs", O_hs, 1);
    check_eq("async_rst vs", O_vs, 1);
    repeat (2) @(negedge I_clk);
    I_enable      = 1'b0;
    I_pattern_sel = 2'd0;
    I_rst_n       = 1'b1;
    de_n = 0; fs_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge I_clk);
      if (O_de) de_n++;
      if (O_frame_start) fs_n++;
    end
    check_eq("post_rst_disabled de", de_n, 0);
    check_eq("post_rst_disabled fs", fs_n, 0);
    I_enable = 1'b1;
    scan_frame("f8_after_rst", 0, 24'h0, 50, -1, 2'd0, 24'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
